// File: rtl/sync_fifo_pkg.sv
// Shared sizing helpers and parameter legality checks for the sync FIFO family.
package sync_fifo_pkg;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // One extra bit so the count can represent DEPTH itself.
  function automatic int cnt_width(input int depth);
    return ptr_width(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit thresholds_ok(input int depth, input int af, input int ae);
    return (af >= 1) && (af <= depth) && (ae >= 0) && (ae <= depth - 1);
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// WIDTH x DEPTH register array: one synchronous write port, one asynchronous read port.
module sync_fifo_ram
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [ptr_width(DEPTH)-1:0]   waddr,
  input  logic [WIDTH-1:0]              wdata,
  input  logic [ptr_width(DEPTH)-1:0]   raddr,
  output logic [WIDTH-1:0]              rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: storage is deliberately not reset; the count and pointers alone decide
  // which entries are meaningful, and leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds,
// sticky overflow/underflow flags and selectable standard/FWFT read mode.
module sync_fifo_flags
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [WIDTH-1:0]            wr_data,
  output logic                        full,
  output logic                        almost_full,
  output logic                        overflow,
  input  logic                        rd_en,
  output logic [WIDTH-1:0]            rd_data,
  output logic                        rd_valid,
  output logic                        empty,
  output logic                        almost_empty,
  output logic                        underflow,
  input  logic                        clr_err,
  output logic [cnt_width(DEPTH)-1:0] cnt
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  if (!is_pow2(DEPTH)) begin : g_bad_depth
    $error("sync_fifo_flags: DEPTH must be a power of two >= 2");
  end
  if (!thresholds_ok(DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_thresh
    $error("sync_fifo_flags: AF_THRESH must be 1..DEPTH and AE_THRESH 0..DEPTH-1");
  end

  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [WIDTH-1:0] ram_rdata;
  logic             wr_acc, rd_acc;

  assign full         = (cnt == DEPTH_C);
  assign empty        = (cnt == '0);
  assign almost_full  = (cnt >= AF_C);
  assign almost_empty = (cnt <= AE_C);

  // Both accepts look only at the pre-edge count, so a full FIFO refuses a
  // write even when a read frees a slot in the same cycle (and vice versa).
  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  sync_fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + PW'(1);

      case ({wr_acc, rd_acc})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase

      // A fresh error in the clearing cycle wins so it is never lost.
      if (wr_en & full)  overflow <= 1'b1;
      else if (clr_err)  overflow <= 1'b0;

      if (rd_en & empty) underflow <= 1'b1;
      else if (clr_err)  underflow <= 1'b0;
    end
  end

  if (FWFT != 0) begin : g_fwft
    // Head word is presented as soon as it is stored; rd_en pops it.
    assign rd_data  = ram_rdata;
    assign rd_valid = ~empty;
  end else begin : g_std
    always_ff @(posedge clk) begin
      if (rst) begin
        rd_data  <= '0;
        rd_valid <= 1'b0;
      end else begin
        rd_valid <= rd_acc;
        if (rd_acc) rd_data <= ram_rdata;
      end
    end
  end

endmodule
